// File: rtl/iobm_pkg.sv
// iobm_ctrl shared types and constants.
// IOBM_VPA_EN enables the 6800 E / VMA peripheral cycle.
package iobm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STRB,
    VPAW,
    DATA,
    TERM
  } state_t;

  localparam int E_PERIOD   = 10;
  localparam int E_HI_START = 6;
  localparam int VMA_SLOT   = 3;

endpackage

// File: rtl/iobm_sync.sv
// N-flop synchronizer plus delay flop, with one-CLK rise/fall pulses.
// Build option IOBM_VPA_EN does not affect this unit.
module iobm_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic nRES,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] sr;
  logic         dly;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sr  <= {N{RST_VAL}};
      dly <= RST_VAL;
    end else begin
      sr  <= {sr[N-2:0], d};
      dly <= sr[N-1];
    end
  end

  assign q    = sr[N-1];
  assign rise = q & ~dly;
  assign fall = ~q & dly;

endmodule

// File: rtl/iobm_ctrl.sv
// I/O bus master sequencer: one 68000-style cycle per IOREQ, timed on C8M.
// Build option IOBM_VPA_EN adds the 6800 E clock and VPA/VMA cycle.
import iobm_pkg::*;

module iobm_ctrl #(
  parameter int TO_CYC      = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic nRES,
  input  logic C8M,
  input  logic IOREQ,
  input  logic IORW0,
  input  logic IOL0,
  input  logic IOU0,
  output logic IOACT,
  output logic IOBERR,
  output logic nAS_IOB,
  output logic nLDS_IOB,
  output logic nUDS_IOB,
  output logic nWE_IOB,
  input  logic nDTACK_IOB,
  input  logic nBERR_IOB,
  input  logic nVPA_IOB,
  output logic nDoutOE,
  output logic nDinLE,
  output logic E,
  output logic nVMA_IOB
);

  localparam int CW = $clog2(TO_CYC + 1);

  logic c8m_q, c_rise, c_fall;
  logic dtack_s, d_r, d_f;
  logic berr_s, b_r, b_f;
  logic vpa_s, v_r, v_f;

  iobm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_c8m (
    .CLK(CLK), .nRES(nRES), .d(C8M),
    .q(c8m_q), .rise(c_rise), .fall(c_fall)
  );
  iobm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_dtack (
    .CLK(CLK), .nRES(nRES), .d(nDTACK_IOB),
    .q(dtack_s), .rise(d_r), .fall(d_f)
  );
  iobm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_berr (
    .CLK(CLK), .nRES(nRES), .d(nBERR_IOB),
    .q(berr_s), .rise(b_r), .fall(b_f)
  );
  iobm_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_vpa (
    .CLK(CLK), .nRES(nRES), .d(nVPA_IOB),
    .q(vpa_s), .rise(v_r), .fall(v_f)
  );

  logic unused_edges;
`ifdef IOBM_VPA_EN
  assign unused_edges = ^{c8m_q, d_r, d_f, b_r, b_f, v_r, v_f};
`else
  assign unused_edges = ^{c8m_q, d_r, d_f, b_r, b_f, v_r, v_f, vpa_s};
`endif

`ifdef IOBM_VPA_EN
  logic [3:0] ecnt;
  logic       e_q;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      ecnt <= 4'd0;
      e_q  <= 1'b0;
    end else if (c_fall) begin
      ecnt <= (ecnt == 4'(E_PERIOD - 1)) ? 4'd0 : ecnt + 4'd1;
      e_q  <= (ecnt >= 4'(E_HI_START - 1)) &&
              (ecnt != 4'(E_PERIOD - 1));
    end
  end

  assign E = e_q;
`else
  assign E        = 1'b0;
  assign nVMA_IOB = 1'b1;
`endif

  state_t        state;
  logic          rw, l, u, berr, armed;
  logic [CW-1:0] tcnt;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state    <= IDLE;
      rw       <= 1'b1;
      l        <= 1'b0;
      u        <= 1'b0;
      berr     <= 1'b0;
      armed    <= 1'b0;
      tcnt     <= '0;
      IOACT    <= 1'b0;
      IOBERR   <= 1'b0;
      nAS_IOB  <= 1'b1;
      nLDS_IOB <= 1'b1;
      nUDS_IOB <= 1'b1;
      nWE_IOB  <= 1'b1;
      nDoutOE  <= 1'b1;
      nDinLE   <= 1'b1;
`ifdef IOBM_VPA_EN
      nVMA_IOB <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: if (c_rise && IOREQ) begin
          rw      <= IORW0;
          l       <= IOL0;
          u       <= IOU0;
          berr    <= 1'b0;
          IOACT   <= 1'b1;
          IOBERR  <= 1'b0;
          nWE_IOB <= IORW0;
          state   <= ADDR;
        end
        ADDR: if (c_fall) begin
          nAS_IOB <= 1'b0;
          if (rw) begin
            nLDS_IOB <= ~l;
            nUDS_IOB <= ~u;
            nDinLE   <= 1'b0;
          end else begin
            nDoutOE  <= 1'b0;
          end
          tcnt  <= '0;
          armed <= 1'b0;
          state <= STRB;
        end
        STRB: begin
          if (c_rise && !rw) begin
            nLDS_IOB <= ~l;
            nUDS_IOB <= ~u;
          end
          // first fall is the strobe settle half; terminations sampled after
          if (c_fall) begin
            if (!armed) armed <= 1'b1;
            else if (!berr_s) begin
              berr  <= 1'b1;
              state <= DATA;
            end
            else if (!dtack_s) state <= DATA;
`ifdef IOBM_VPA_EN
            else if (!vpa_s) state <= VPAW;
`endif
            else if (tcnt == CW'(TO_CYC - 1)) begin
              berr  <= 1'b1;
              state <= DATA;
            end
            else tcnt <= tcnt + CW'(1);
          end
        end
`ifdef IOBM_VPA_EN
        VPAW: if (c_fall) begin
          if (ecnt == 4'(VMA_SLOT)) nVMA_IOB <= 1'b0;
          if (!nVMA_IOB && ecnt == 4'(E_PERIOD - 1)) state <= DATA;
        end
`endif
        DATA: if (c_fall) begin
          nDinLE   <= 1'b1;
          nAS_IOB  <= 1'b1;
          nLDS_IOB <= 1'b1;
          nUDS_IOB <= 1'b1;
`ifdef IOBM_VPA_EN
          nVMA_IOB <= 1'b1;
`endif
          state    <= TERM;
        end
        TERM: if (c_rise) begin
          nDoutOE <= 1'b1;
          nWE_IOB <= 1'b1;
          IOACT   <= 1'b0;
          IOBERR  <= berr;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iobm_ctrl.sv
// Scoreboard bench for iobm_ctrl: random bus cycles vs. a cycle-count model.
// Default build (IOBM_VPA_EN undefined); /VPA is held negated.
module tb_iobm_ctrl;

  localparam int TO  = 8;
  localparam int PER = 20;

  logic CLK = 1'b0;
  logic nRES = 1'b0;
  logic C8M = 1'b0;
  logic IOREQ = 1'b0;
  logic IORW0 = 1'b1;
  logic IOL0 = 1'b0;
  logic IOU0 = 1'b0;
  logic nDTACK_IOB = 1'b1;
  logic nBERR_IOB = 1'b1;
  logic nVPA_IOB = 1'b1;
  logic IOACT, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB, nWE_IOB;
  logic nDoutOE, nDinLE, E, nVMA_IOB;

  iobm_ctrl #(.TO_CYC(TO), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .nRES(nRES), .C8M(C8M), .IOREQ(IOREQ),
    .IORW0(IORW0), .IOL0(IOL0), .IOU0(IOU0),
    .IOACT(IOACT), .IOBERR(IOBERR),
    .nAS_IOB(nAS_IOB), .nLDS_IOB(nLDS_IOB),
    .nUDS_IOB(nUDS_IOB), .nWE_IOB(nWE_IOB),
    .nDTACK_IOB(nDTACK_IOB), .nBERR_IOB(nBERR_IOB),
    .nVPA_IOB(nVPA_IOB), .nDoutOE(nDoutOE), .nDinLE(nDinLE),
    .E(E), .nVMA_IOB(nVMA_IOB)
  );

  always #5 CLK = ~CLK;
  initial begin
    #3;
    forever #100 C8M = ~C8M;
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit rw;
    bit l;
    bit u;
    bit berr;
    int len;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  bit abort = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int idle_vec();
    return {IOACT, IOBERR, nAS_IOB, nLDS_IOB, nUDS_IOB,
            nWE_IOB, nDoutOE, nDinLE, nVMA_IOB, E};
  endfunction

  // monitor: watch each IOACT window, check against the scoreboard at its end
  initial begin
    bit act_d = 1'b0;
    int t0 = 0, as_t = -1, ds_t = -1;
    bit lds_lo, uds_lo, oe_lo, le_lo, we_v;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (IOACT && !act_d) begin
        t0 = cyc; as_t = -1; ds_t = -1;
        lds_lo = 0; uds_lo = 0; oe_lo = 0; le_lo = 0; we_v = 0;
      end
      if (IOACT) begin
        if (!nAS_IOB && as_t < 0) begin
          as_t = cyc;
          we_v = nWE_IOB;
        end
        if ((!nLDS_IOB || !nUDS_IOB) && ds_t < 0) ds_t = cyc;
        lds_lo |= !nLDS_IOB;
        uds_lo |= !nUDS_IOB;
        oe_lo  |= !nDoutOE;
        le_lo  |= !nDinLE;
      end
      if (!IOACT && act_d && !abort) begin
        if (sb.size() == 0) chk("unexpected_cycle", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ioberr", IOBERR, e.berr);
          chk("cycle_clks", cyc - t0, e.len * PER);
          chk("lds_used", lds_lo, e.l);
          chk("uds_used", uds_lo, e.u);
          chk("nwe_level", we_v, e.rw);
          chk("doutoe_used", oe_lo, !e.rw);
          chk("dinle_used", le_lo, e.rw);
          if (e.l || e.u)
            chk("ds_after_as", ds_t - as_t, e.rw ? 0 : PER / 2);
          chk("released", idle_vec() & 10'h0FF, 10'h0FE);
        end
      end
      act_d = IOACT;
    end
  end

  task automatic wait_lvl(input string name, input bit want_act,
                          input bit use_as, input int limit, output bit ok);
    int n = 0;
    while (((use_as ? !nAS_IOB : IOACT) != want_act) && n < limit) begin
      @(negedge CLK);
      n++;
    end
    ok = ((use_as ? !nAS_IOB : IOACT) == want_act);
    if (!ok) chk(name, 0, 1);
  endtask

  // one bus cycle; w = sampling falls before /DTACK, never = no /DTACK
  task automatic run(input bit rw, input bit l, input bit u,
                     input int w, input bit both, input bit never);
    exp_t e;
    bit ok;
    e.rw = rw; e.l = l; e.u = u;
    e.berr = never ? 1'b1 : both;
    e.len = never ? 3 + TO : 4 + w;
    sb.push_back(e);
    @(negedge CLK);
    IORW0 = rw; IOL0 = l; IOU0 = u; IOREQ = 1'b1;
    wait_lvl("ioact_rise_timeout", 1'b1, 1'b0, 4 * PER, ok);
    IOREQ = 1'b0;
    if (!ok) begin
      void'(sb.pop_back());
      return;
    end
    wait_lvl("nas_fall_timeout", 1'b1, 1'b1, 2 * PER, ok);
    if (ok && !never) begin
      repeat (2 + w) @(posedge C8M);
      #1;
      nDTACK_IOB = 1'b0;
      if (both) nBERR_IOB = 1'b0;
    end
    wait_lvl("ioact_fall_timeout", 1'b0, 1'b0, (TO + 8) * PER, ok);
    nDTACK_IOB = 1'b1;
    nBERR_IOB = 1'b1;
    repeat (PER + 5) @(negedge CLK);
  endtask

  initial begin
    bit ok;
    repeat (4) @(negedge CLK);
    chk("reset_outputs", idle_vec(), 10'h0FE);
    nRES = 1'b1;
    repeat (2 * PER) @(negedge CLK);
    chk("idle_outputs", idle_vec(), 10'h0FE);

    run(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    run(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk("ioberr_holds", IOBERR, 1);
    run(1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    run(1'b1, 1'b1, 1'b1, TO - 1, 1'b0, 1'b0);

    // asynchronous reset while waiting in STRB
    @(negedge CLK);
    IORW0 = 1'b0; IOL0 = 1'b1; IOU0 = 1'b1; IOREQ = 1'b1;
    wait_lvl("abort_ioact_timeout", 1'b1, 1'b0, 4 * PER, ok);
    IOREQ = 1'b0;
    wait_lvl("abort_nas_timeout", 1'b1, 1'b1, 2 * PER, ok);
    repeat (2) @(posedge C8M);
    #7;
    abort = 1'b1;
    nRES = 1'b0;
    #1;
    chk("reset_abort", idle_vec(), 10'h0FE);
    repeat (3) @(negedge CLK);
    nRES = 1'b1;
    repeat (3) @(negedge CLK);
    abort = 1'b0;
    repeat (PER) @(negedge CLK);

    run(1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      bit rw, l, u, both;
      int w;
      rw = 1'($urandom % 2);
      l = 1'($urandom % 2);
      u = 1'($urandom % 2);
      w = int'($urandom_range(0, 4));
      both = ($urandom % 6) == 0;
      run(rw, l, u, w, both, 1'b0);
    end

    repeat (PER) @(negedge CLK);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iobm_ctrl.md
Name: iobm_ctrl

Overview:
- I/O bus master sequencer. Executes the single transfer staged in the primary FIFO level (IORW0/IOL0/IOU0, address/data latches) as a 68000-style bus cycle on the slow I/O bus.
- Runs in the fast CLK domain and times every strobe from synchronized C8M edges.
- Answers the bridge's IOREQ with the IOACT/IOBERR handshake.

Parameters:
- TO_CYC, 255: C8M cycles spent waiting for /DTACK before a timeout bus error; counter width is $clog2(TO_CYC+1).
- SYNC_STAGES, 2: synchronizer depth for C8M and the bus termination inputs.

Ports:
- CLK  in  1  fast system clock.
- nRES  in  1  asynchronous active-low reset.
- C8M  in  1  I/O bus clock, asynchronous to CLK.
- IOREQ  in  1  transfer request from the bridge.
- IORW0  in  1  primary-level R/W (1 = read).
- IOL0  in  1  primary-level lower-byte strobe request.
- IOU0  in  1  primary-level upper-byte strobe request.
- IOACT  out  1  transfer in progress.
- IOBERR  out  1  last transfer ended in a bus error; valid when IOACT falls.
- nAS_IOB, nLDS_IOB, nUDS_IOB, nWE_IOB  out  1 each  I/O bus strobes.
- nDTACK_IOB, nBERR_IOB, nVPA_IOB  in  1 each  I/O bus termination inputs.
- nDoutOE  out  1  write-data drivers enable.
- nDinLE  out  1  read-data latch enable; latch is transparent while low.
- E, nVMA_IOB  out  1 each  6800 peripheral clock and valid-memory-address strobe.

Behaviour:
- Clock and reset: one clock, CLK. nRES is asynchronous, active-low.
- Reset values: IOACT=0, IOBERR=0, all n-outputs=1, E=0, state=IDLE, timeout counter=0. Reset mid-cycle aborts it immediately: all strobes negate and no IOBERR is reported.
- Edge detection:
  - C8M passes SYNC_STAGES flops plus one delay flop.
  - rise = sync & !dly; fall = !sync & dly. Each is a one-CLK pulse.
  - nDTACK_IOB, nBERR_IOB and nVPA_IOB are synchronized the same way and sampled only on fall pulses.
- States; each advances only on the named pulse:
  - IDLE: on rise with IOREQ=1, latch IORW0/IOL0/IOU0. Set IOACT=1 and IOBERR=0. nWE_IOB = latched RW. Go to ADDR.
  - ADDR: on fall, nAS_IOB=0.
    - Read: nLDS_IOB/nUDS_IOB = !IOL/!IOU, and nDinLE=0.
    - Write: nDoutOE=0.
    - Clear the timeout counter and go to STRB.
  - STRB: on the first rise, a write asserts its byte strobes. On each fall, sample, in this priority:
    1. BERR low: set berr flag, go to DATA.
    2. DTACK low: go to DATA.
    3. VPA low (feature only): go to VPAW.
    4. Counter == TO_CYC-1: set berr flag, go to DATA.
    5. Otherwise increment the counter.
    - DTACK and timeout on the same edge: DTACK wins. BERR and DTACK together: BERR wins.
  - DATA: on fall, nDinLE=1 (closes the read latch), then nAS/nLDS/nUDS=1. Go to TERM.
  - TERM: on rise, nDoutOE=1, nWE_IOB=1, IOACT=0, IOBERR=berr flag. Go to IDLE.
- IOBERR holds until the next IDLE→ADDR transition.
- IOREQ deasserting after IOACT rises has no effect on the cycle in flight.
- A new cycle cannot start on the same rise that ends TERM. Minimum one full C8M period between cycles.
- Latency, with no wait states: IOREQ to IOACT ≤ 1 C8M period + sync delay; a full cycle is 4 C8M periods.

Optional Feature:
- Macro: IOBM_VPA_EN.
- Defined:
  - A 0..9 counter advances on C8M fall; E=1 while count ∈ 6..9.
  - From STRB, VPA low enters VPAW and sets nVMA_IOB=0 on the next fall where count==3.
  - VPAW leaves for DATA on the fall where count wraps 9→0; nVMA_IOB=1 together with nAS.
  - The timeout counter is frozen in VPAW.
- Undefined: E=0, nVMA_IOB=1, nVPA_IOB ignored; VPAW is unreachable and not synthesized.

Decomposition:
- Package iobm_pkg: state enum (IDLE, ADDR, STRB, VPAW, DATA, TERM), E_PERIOD=10, E_HI_START=6, VMA_SLOT=3.
- Sub-module iobm_sync: parameterized N-flop synchronizer with rise/fall pulse outputs, instantiated for C8M and the three termination inputs.

Test Plan:
- Read, L=U=1, /DTACK low from reset → nAS low on the fall after IOACT rises; nLDS and nUDS low with it; nDinLE high on the DATA fall; IOACT low 4 C8M periods after rising; IOBERR=0.
- Write, U only, /DTACK after 3 wait cycles → nDoutOE low from ADDR; nUDS low one half-period after nAS; nLDS stays high; cycle length 7 C8M periods.
- TO_CYC=8, no /DTACK → IOBERR=1 when IOACT falls after 8 STRB falls; strobes released cleanly.
- /BERR and /DTACK asserted together on one fall → IOBERR=1. /DTACK on the timeout edge → IOBERR=0.
- nRES pulsed low during STRB → all strobes high and IOACT=0 asynchronously; next IOREQ runs a normal cycle.
- With IOBM_VPA_EN, /VPA low → nVMA low at E count 3; cycle ends on the E falling edge; E high for 4 and low for 6 C8M periods.
